// File: rtl/swpoll_pkg.sv
`default_nettype none
// ============================================================================
// Module      : swpoll_pkg
// Description : Shared defaults and event-entry type for the switch poller
//               and its command-interpreter consumer.
// Revision    : 1.0 - initial release
// ============================================================================
package swpoll_pkg;

    localparam int unsigned c_NUM_SW     = 7;
    localparam int unsigned c_DIV        = 1000;
    localparam int unsigned c_DEBOUNCE   = 6;
    localparam int unsigned c_FIFO_DEPTH = 4;

    // Index field is sized for the largest legal channel count (16).
    localparam int unsigned c_IDX_W_MAX  = 4;

    typedef struct packed {
        logic [c_IDX_W_MAX-1:0] idx;
        logic                   rise;
    } swpoll_evt_t;

    function automatic swpoll_evt_t swpoll_make_evt(input logic [c_IDX_W_MAX-1:0] idx,
                                                    input logic rise);
        swpoll_evt_t e;
        e.idx  = idx;
        e.rise = rise;
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/swpoll_debounce.sv
`default_nettype none
// ============================================================================
// Module      : swpoll_debounce
// Description : One switch channel: 2-flop synchroniser, sample history,
//               debounced level and a one-cycle level-change pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module swpoll_debounce
    import swpoll_pkg::*;
#(
    parameter int DEBOUNCE = c_DEBOUNCE
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sw,
    input  logic i_tick,
    output logic o_level,
    output logic o_edge
);

    logic                r_s1;
    logic                r_s2;
    logic [DEBOUNCE-1:0] r_hist;
    logic                r_level;
    logic [DEBOUNCE-1:0] w_hist_nxt;
    logic                w_to_one;
    logic                w_to_zero;

    // Decide on the history as it will be after this tick's shift.
    assign w_hist_nxt = {r_hist[DEBOUNCE-2:0], r_s2};
    assign w_to_one   = (&w_hist_nxt) && !r_level;
    assign w_to_zero  = !(|w_hist_nxt) && r_level;
    assign o_edge     = i_tick && (w_to_one || w_to_zero);
    assign o_level    = r_level;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_hist  <= '0;
            r_level <= 1'b0;
        end else begin
            r_s1 <= i_sw;
            r_s2 <= r_s1;
            if (i_tick) begin
                r_hist <= w_hist_nxt;
                if (w_to_one) begin
                    r_level <= 1'b1;
                end else if (w_to_zero) begin
                    r_level <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/switch_event_poller.sv
`default_nettype none
// ============================================================================
// Module      : switch_event_poller
// Description : Debounces NUM_SW switches and queues press (and, with
//               SWPOLL_RELEASE_EN defined, release) events into a FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module switch_event_poller
    import swpoll_pkg::*;
#(
    parameter int NUM_SW     = c_NUM_SW,
    parameter int DIV        = c_DIV,
    parameter int DEBOUNCE   = c_DEBOUNCE,
    parameter int FIFO_DEPTH = c_FIFO_DEPTH,
    parameter int IDX_W      = (NUM_SW > 1) ? $clog2(NUM_SW) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_SW-1:0] sw_in,
    output logic [NUM_SW-1:0] sw_level,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [IDX_W-1:0]  evt_idx,
    output logic              evt_rise,
    output logic              overflow,
    input  logic              ovf_clr
);

    localparam int c_CNT_W = $clog2(DIV);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);

    logic [c_CNT_W-1:0] r_cnt;
    logic               w_tick;
    logic [NUM_SW-1:0]  w_edge;
    logic [NUM_SW-1:0]  w_rise_new;
    logic [NUM_SW-1:0]  r_rise_pend;
    logic [NUM_SW-1:0]  w_rise_nxt;
    logic [NUM_SW-1:0]  w_pend;
`ifdef SWPOLL_RELEASE_EN
    logic [NUM_SW-1:0]  w_fall_new;
    logic [NUM_SW-1:0]  r_fall_pend;
    logic [NUM_SW-1:0]  w_fall_nxt;
`endif
    logic               w_any;
    logic [IDX_W-1:0]   w_sel_idx;
    logic               w_sel_rise;
    logic [NUM_SW-1:0]  w_sel_oh;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_ovf_set;
    logic               r_ovf;

    swpoll_evt_t        r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;

    assign w_tick = (r_cnt == c_CNT_W'(DIV - 1));

    for (genvar i = 0; i < NUM_SW; i++) begin : g_ch
        swpoll_debounce #(
            .DEBOUNCE (DEBOUNCE)
        ) u_deb (
            .clk     (clk),
            .rst     (rst),
            .i_sw    (sw_in[i]),
            .i_tick  (w_tick),
            .o_level (sw_level[i]),
            .o_edge  (w_edge[i])
        );
    end

    // sw_level still holds the pre-change value during the edge pulse.
    assign w_rise_new = w_edge & ~sw_level;
`ifdef SWPOLL_RELEASE_EN
    assign w_fall_new = w_edge & sw_level;
    assign w_pend     = r_rise_pend | r_fall_pend;
`else
    assign w_pend     = r_rise_pend;
`endif

    // Lowest pending channel wins; a rise pending outranks a fall.
    always_comb begin
        w_any      = 1'b0;
        w_sel_idx  = '0;
        w_sel_rise = 1'b0;
        w_sel_oh   = '0;
        for (int i = NUM_SW - 1; i >= 0; i--) begin
            if (w_pend[i]) begin
                w_any       = 1'b1;
                w_sel_idx   = IDX_W'(i);
                w_sel_rise  = r_rise_pend[i];
                w_sel_oh    = '0;
                w_sel_oh[i] = 1'b1;
            end
        end
    end

    assign evt_valid = (r_count != '0);
    assign w_full    = (r_count == (c_PTR_W + 1)'(FIFO_DEPTH));
    assign w_pop     = evt_valid && evt_ready;
    assign w_push    = w_any && (!w_full || w_pop);

    always_comb begin
        w_rise_nxt = r_rise_pend & ~((w_push && w_sel_rise) ? w_sel_oh : '0);
`ifdef SWPOLL_RELEASE_EN
        w_fall_nxt = r_fall_pend & ~((w_push && !w_sel_rise) ? w_sel_oh : '0);
        // A new edge against a still-pending opposite edge replaces it.
        w_ovf_set  = (|(w_rise_new & w_fall_nxt)) || (|(w_fall_new & w_rise_nxt));
        w_fall_nxt = (w_fall_nxt & ~w_rise_new) | w_fall_new;
        w_rise_nxt = (w_rise_nxt & ~w_fall_new) | w_rise_new;
`else
        w_ovf_set  = 1'b0;
        w_rise_nxt = w_rise_nxt | w_rise_new;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_rise_pend <= '0;
`ifdef SWPOLL_RELEASE_EN
            r_fall_pend <= '0;
`endif
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
        end else begin
            r_cnt       <= w_tick ? '0 : r_cnt + c_CNT_W'(1);
            r_rise_pend <= w_rise_nxt;
`ifdef SWPOLL_RELEASE_EN
            r_fall_pend <= w_fall_nxt;
`endif
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= swpoll_make_evt(c_IDX_W_MAX'(w_sel_idx), w_sel_rise);
        end
    end

    // Head fields are forced to zero while the queue is empty.
    assign evt_idx  = evt_valid ? r_mem[r_rd_ptr].idx[IDX_W-1:0] : '0;
`ifdef SWPOLL_RELEASE_EN
    assign evt_rise = evt_valid && r_mem[r_rd_ptr].rise;
`else
    assign evt_rise = evt_valid;
`endif
    assign overflow = r_ovf;

endmodule
`default_nettype wire

// File: doc/switch_event_poller.md
# switch_event_poller

Parametrised successor to the single-event switch poller. It synchronises and debounces `NUM_SW` push-switch inputs on a divided sample tick and tracks a debounced level per channel. Press events, and optionally release events, are queued into a small FIFO and presented to the command interpreter FSM over a valid/ready handshake. Simultaneous presses are never lost, and the poller no longer relies on a timed self-clear of its output.

## Interface
Parameters:
- `NUM_SW`, 7: number of switch channels (1..16).
- `DIV`, 1000: `clk` cycles per sample tick (≥ 2).
- `DEBOUNCE`, 6: consecutive identical samples required to change the debounced level (2..16).
- `FIFO_DEPTH`, 4: event queue entries; must be a power of two (2..16).
- `IDX_W`, `$clog2(NUM_SW)` (min 1): width of the channel index.

Ports:
- `clk`  in  1: 50 MHz system clock. One clock domain only.
- `rst`  in  1: reset, synchronous, active-high.
- `sw_in`  in  `NUM_SW`: raw asynchronous switch inputs, active-high.
- `sw_level`  out  `NUM_SW`: debounced level per channel.
- `evt_valid`  out  1: FIFO head holds an event.
- `evt_ready`  in  1: consumer accepts the head event.
- `evt_idx`  out  `IDX_W`: channel index of the head event.
- `evt_rise`  out  1: head event type; 1 = press, 0 = release.
- `overflow`  out  1: sticky flag, set when an event was lost.
- `ovf_clr`  in  1: clears `overflow`.

## Operation
- **Synchroniser:** 2-flop chain per channel, clocked every `clk`.
- **Tick counter:** runs 0..`DIV`-1 and wraps. `tick` is asserted for one cycle when the count equals `DIV`-1.
- **Sampling:** on a `tick` cycle, each channel shifts its synchronised value into a `DEBOUNCE`-bit history register.
- **Level update:** decided on the new history value.
  - All ones while level is 0: level becomes 1 and the channel's rise-pending bit is set.
  - All zeros while level is 1: level becomes 0 and the fall-pending bit is set.
  - Any other history: no change.
- **Arbiter:** each cycle it selects the lowest-index channel with a pending bit. Rise is chosen before fall on the same channel. It pushes {idx, rise} into the FIFO and clears that pending bit. One push per cycle at most.
- **Push condition:** a push happens only if the FIFO is not full, or a pop occurs in the same cycle. Otherwise pending bits are held.
- **Overwrite on collision:** if a new edge arrives on a channel that already has a pending bit of the opposite type, the older pending bit is cleared, the new one is set, and `overflow` is set.
- **FIFO:** show-ahead. `evt_valid` = not empty and `evt_idx`/`evt_rise` show the head entry. A pop occurs on `evt_valid && evt_ready`. `evt_ready` while empty is ignored.
- **Overflow clear:** `ovf_clr` clears `overflow`. If a set condition occurs in the same cycle, set wins.
- **Reset values:** on `rst`, the following all go to 0:
  - synchronisers, histories, `sw_level`, pending bits, tick counter;
  - FIFO pointers and count, so `evt_valid` = 0 and `evt_idx`/`evt_rise` = 0;
  - `overflow`.
- **Reset mid-operation:** queued and pending events are discarded. Switches held at reset re-report as presses after `DEBOUNCE` ticks.

## Timing
- Input to synchronised value: 2 `clk` cycles.
- Level change: `sw_level` and the pending bit update on the edge that ends the tick cycle completing `DEBOUNCE` matching samples (edge T).
- FIFO write occurs at edge T+1 if the FIFO has room. `evt_valid` is high from cycle T+1 onward.
- Worst-case press latency: 2 + `DEBOUNCE`·`DIV` + 1 cycles after a stable input change, with an empty FIFO.
- N simultaneous qualifying channels enter the FIFO on N consecutive cycles, in ascending index order.
- A pop takes effect on the clock edge where `evt_valid && evt_ready`. The next entry appears in the following cycle with no bubble.

## Configuration
- `SWPOLL_RELEASE_EN` defined: release (fall) events are queued with `evt_rise` = 0.
- `SWPOLL_RELEASE_EN` undefined:
  - fall-pending logic is removed and `evt_rise` is tied to 1;
  - `sw_level` still tracks releases;
  - only presses are queued.

## Structure
- Shared package `swpoll_pkg` holds:
  - the default constants `NUM_SW`, `DIV`, `DEBOUNCE` and `FIFO_DEPTH`;
  - the event entry typedef {idx, rise}, so the command FSM decodes queue entries consistently.
- Sub-module `swpoll_debounce`: one channel, containing the synchroniser, history, level and edge pulses. It is instantiated `NUM_SW` times via generate.
- The arbiter and FIFO live in the top level.

## Test plan
- **Reset:** `rst` is held 3 cycles with `sw_in` = 7'h7F.
  - During reset, all outputs are 0.
  - After release, `sw_level` reaches 7'h7F after ~`DEBOUNCE`·`DIV` cycles.
  - Events for idx 0..6 (rise) follow on consecutive cycles.
- **Bounce rejection** (`DIV`=4, `DEBOUNCE`=6): `sw_in[2]` toggles every 3 ticks for 20 ticks, then holds 1.
  - No event occurs during the toggling.
  - Exactly one event {2, rise} occurs after 6 stable ticks.
- **Simultaneous press:** `sw_in[5]` and `sw_in[1]` rise in the same cycle with `evt_ready` = 1.
  - Events {1, 1} then {5, 1} occur on adjacent cycles.
- **Full FIFO / backpressure** (`FIFO_DEPTH`=4): `evt_ready` = 0 while 5 channels are pressed.
  - Four entries are queued and the fifth stays pending.
  - When `evt_ready` is raised, all 5 events are delivered in index order and `overflow` stays 0.
- **Collision:** with `evt_ready` = 0 and the FIFO full, press then fully release ch 3.
  - `overflow` = 1.
  - Only {3, 0} is delivered once the FIFO drains.
  - `ovf_clr` then clears `overflow`.
- **Release option:** press and release ch 0 with `SWPOLL_RELEASE_EN` defined.
  - Events {0, 1} then {0, 0} are delivered.
  - With the macro undefined, only {0, 1} is delivered.
